// File: rtl/song_pkg.sv
// song_pkg - note constants, FSM states and table entry type for the song sequencer
package song_pkg;

    localparam int NOTE_PERIOD_W = 20;
    localparam int NOTE_DUR_W    = 5;

    // Half-periods in cycles of a 100 MHz clock
    localparam int NOTE_C4 = 191110;
    localparam int NOTE_D4 = 170265;
    localparam int NOTE_E4 = 151686;
    localparam int NOTE_F4 = 143173;
    localparam int NOTE_G4 = 127551;
    localparam int NOTE_A4 = 113636;
    localparam int NOTE_B4 = 101239;
    localparam int NOTE_C5 = 95556;
    localparam int NOTE_D5 = 85131;
    localparam int NOTE_E5 = 75843;
    localparam int NOTE_F5 = 71586;
    localparam int NOTE_G5 = 63776;
    localparam int NOTE_A5 = 56818;
    localparam int NOTE_B5 = 50619;
    localparam int REST     = 0;
    localparam int END_MARK = 0;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} seq_state_t;

    typedef struct packed {
        logic [NOTE_PERIOD_W-1:0] period;
        logic [NOTE_DUR_W-1:0]    duration;
    } note_entry_t;

endpackage

// File: rtl/song_sequencer_if.sv
// rtl/song_sequencer_if.sv - control and audio status bundle of the song sequencer
interface song_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              enable;
    logic              play;
    logic              loop_mode;
    logic              aud_out;
    logic              aud_sd;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] note_idx;

    modport master (
        output enable, play, loop_mode,
        input  aud_out, aud_sd, busy, done, note_idx
    );

    modport slave (
        input  enable, play, loop_mode,
        output aud_out, aud_sd, busy, done, note_idx
    );
endinterface

// File: rtl/song_rom.sv
// rtl/song_rom.sv - combinational note table; SONG_ID selects the melody
module song_rom
    import song_pkg::*;
#(
    parameter int SONG_LEN = 64,
    parameter int PERIOD_W = NOTE_PERIOD_W,
    parameter int DUR_W    = NOTE_DUR_W,
    parameter int SONG_ID  = 0,
    parameter int ADDR_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output note_entry_t       entry
);

    function automatic note_entry_t mk(input int period, input int duration);
        note_entry_t e;
        e.period   = NOTE_PERIOD_W'(PERIOD_W'(period));
        e.duration = NOTE_DUR_W'(DUR_W'(duration));
        return e;
    endfunction

    always_comb begin
        entry = mk(REST, END_MARK);
        case (SONG_ID)
            1: case (int'(addr))
                0: entry = mk(5, 2);
                1: entry = mk(REST, 1);
                2: entry = mk(3, 1);
                default: ;
            endcase
            2: case (int'(addr))
                0: entry = mk(2, 1);
                1: entry = mk(3, 1);
                2: entry = mk(4, 1);
                3: entry = mk(2, 1);
                default: ;
            endcase
            default: case (int'(addr))
                0: entry = mk(NOTE_E5, 2);
                1: entry = mk(NOTE_G5, 2);
                2: entry = mk(NOTE_E5, 2);
                3: entry = mk(REST, 1);
                4: entry = mk(NOTE_C5, 4);
                5: entry = mk(NOTE_A4, 4);
                default: ;
            endcase
        endcase
    end

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - note-table sequencer driving a square-wave alarm tone
module song_sequencer
    import song_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int UNIT_DIV = 8,
    parameter int SONG_LEN = 64,
    parameter int PERIOD_W = NOTE_PERIOD_W,
    parameter int DUR_W    = NOTE_DUR_W,
    parameter int GAP_CYC  = CLK_FREQ / 100,
    parameter int SONG_ID  = 0
) (
    input logic             clk,
    input logic             rst_n,
    song_sequencer_if.slave bus
);

    localparam int ADDR_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int DCNT_W   = DUR_W + 32;
    localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [DCNT_W-1:0] TICKS_PER_UNIT = DCNT_W'(CLK_FREQ / UNIT_DIV);

    seq_state_t         state;
    logic [ADDR_W-1:0]  note_idx;
    logic [PERIOD_W-1:0] period_q, per_cnt;
    logic [DUR_W-1:0]   dur_q;
    logic [DCNT_W-1:0]  dur_cnt, dur_last;
    logic [GAP_W-1:0]   gap_cnt;
    logic               aud_out, aud_sd, busy, done;
    note_entry_t        rom_entry;

    logic               song_end;
    seq_state_t         adv_state;
    logic [ADDR_W-1:0]  adv_idx;
    logic               adv_done;

    song_rom #(
        .SONG_LEN (SONG_LEN),
        .PERIOD_W (PERIOD_W),
        .DUR_W    (DUR_W),
        .SONG_ID  (SONG_ID),
        .ADDR_W   (ADDR_W)
    ) u_rom (
        .addr  (note_idx),
        .entry (rom_entry)
    );

    assign dur_last = DCNT_W'(dur_q) * TICKS_PER_UNIT - DCNT_W'(1);

    // Shared "move to the next entry" decision: used by LOAD on an end marker
    // and by PLAY/GAP when a note finishes.
    always_comb begin
        song_end  = (state == LOAD) ? (rom_entry.duration == '0)
                                    : (note_idx == ADDR_W'(SONG_LEN - 1));
        adv_state = LOAD;
        adv_idx   = note_idx + ADDR_W'(1);
        adv_done  = 1'b0;
        if (song_end) begin
            if (bus.loop_mode) begin
                adv_idx = '0;
            end else begin
                adv_state = DONE;
                adv_idx   = note_idx;
                adv_done  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            note_idx <= '0;
            period_q <= '0;
            dur_q    <= '0;
            per_cnt  <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
            aud_out  <= 1'b0;
            aud_sd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (!bus.enable) begin
            state    <= IDLE;
            note_idx <= '0;
            period_q <= '0;
            dur_q    <= '0;
            per_cnt  <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
            aud_out  <= 1'b0;
            aud_sd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            aud_sd <= 1'b1;
            done   <= 1'b0;
            case (state)
                IDLE: if (bus.play) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: if (bus.play) begin
                    period_q <= PERIOD_W'(rom_entry.period);
                    dur_q    <= DUR_W'(rom_entry.duration);
                    per_cnt  <= '0;
                    dur_cnt  <= '0;
                    aud_out  <= 1'b0;
                    if (song_end) begin
                        state    <= adv_state;
                        note_idx <= adv_idx;
                        busy     <= !adv_done;
                        done     <= adv_done;
                    end else begin
                        state <= PLAY;
                    end
                end
                PLAY: if (bus.play) begin
                    if (dur_cnt == dur_last) begin
                        aud_out <= 1'b0;
                        per_cnt <= '0;
                        dur_cnt <= '0;
                        gap_cnt <= '0;
                        if (GAP_CYC == 0) begin
                            state    <= adv_state;
                            note_idx <= adv_idx;
                            busy     <= !adv_done;
                            done     <= adv_done;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + DCNT_W'(1);
                        // A zero half-period is a rest: stay silent, leave the divider idle.
                        if (period_q == '0) begin
                            aud_out <= 1'b0;
                        end else if (per_cnt == period_q - PERIOD_W'(1)) begin
                            per_cnt <= '0;
                            aud_out <= ~aud_out;
                        end else begin
                            per_cnt <= per_cnt + PERIOD_W'(1);
                        end
                    end
                end
                GAP: if (bus.play) begin
                    aud_out <= 1'b0;
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        gap_cnt  <= '0;
                        state    <= adv_state;
                        note_idx <= adv_idx;
                        busy     <= !adv_done;
                        done     <= adv_done;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                DONE: begin
                    aud_out <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.aud_out  = aud_out;
    assign bus.aud_sd   = aud_sd;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.note_idx = note_idx;

endmodule
